mem_word_port: RTL and testbench

// - Initiator for the byte-write / word-read data memory: turns 32-bit word read/write requests into memory-side ops.
// - Word write = four sequential byte writes (memory accepts one byte per cycle); word read = one registered 4-byte read.
// - Sits between the NoC node's load/store logic (upstream valid/ready) and the Memory instance (downstream enables).

---
 rtl/mem_port_pkg.sv | 19 +
 rtl/mem_word_port.sv | 122 ++++++++++++
 tb/tb_mem_word_port.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the word-to-byte memory port.
`default_nettype none

package mem_port_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BEAT_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_word_port.sv
// Word request initiator for a byte-write / word-read memory: a word write
// becomes four byte beats, a word read becomes one registered 4-byte read.
`default_nettype none

module mem_word_port
  import mem_port_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int MEM_SIZE = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  // One extra bit so the range compare cannot itself wrap.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_SIZE - BYTES_PER_WORD);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [BEAT_W-1:0]   beat;
  logic                accept;
  logic                addr_oob;

  assign accept   = req_valid && (state == ST_IDLE);
  assign addr_oob = {1'b0, req_addr} > LAST_ADDR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (addr_oob)       next_state = ST_RESP;
          else if (req_write) next_state = ST_WRITE;
          else                next_state = ST_RD_ISSUE;
        end
      end
      ST_WRITE:    if (beat == BEAT_W'(BYTES_PER_WORD - 1)) next_state = ST_RESP;
      ST_RD_ISSUE: next_state = ST_RD_CAPT;
      ST_RD_CAPT:  next_state = ST_RESP;
      ST_RESP:     if (rsp_ready) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      beat      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            beat      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= addr_oob;
          end
        end
        ST_WRITE:   beat <= beat + 1'b1;
        // Memory output is only valid for this one cycle after the read strobe.
        ST_RD_CAPT: rsp_rdata <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      ST_WRITE: begin
        mem_addr  = addr_q + ADDR_W'(beat);
        mem_wdata = wdata_q[{beat, 3'b000} +: 8];
        mem_we    = be_q[beat];
      end
      ST_RD_ISSUE: begin
        mem_addr = addr_q;
        mem_re   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_word_port.sv
// Directed bench for mem_word_port against a behavioural byte-write / word-read memory.
`default_nettype none

module tb_mem_word_port;

  localparam int ADDR_W   = 8;
  localparam int MEM_SIZE = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_be    = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;

  logic [7:0] mem [MEM_SIZE];
  logic       mem_clear = 1'b1;
  int         re_pulses = 0;
  int         we_pulses = 0;
  int         n_pass    = 0;
  int         n_total   = 0;

  always #5 clk = ~clk;

  mem_word_port #(.ADDR_W(ADDR_W), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Memory: one byte written per cycle, registered 4-byte little-endian read, zero when not reading.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 8'h00;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                                mem[mem_addr + 8'd1], mem[mem_addr]};
      else        mem_rdata <= '0;
    end
  end

  always @(posedge clk) begin
    if (mem_re) re_pulses++;
    if (mem_we) we_pulses++;
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called 1ns after a rising edge while idle; returns cycles to rsp_valid and the response.
  task automatic txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] be, output int lat, output logic [31:0] rd,
                     output logic err);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_be = ~be;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err;
    int          base;
    logic        hold_ok;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_re",    32'(mem_re), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    mem_clear = 1'b0;
    @(posedge clk); #1;

    // Full word write then read back
    txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, lat, rd, err);
    chk("wr10_lat", 32'(lat), 32'd5);
    chk("wr10_err", 32'(err), 32'd0);
    chk("wr10_rdata", rd, 32'd0);
    chk("wr10_mem", mem_word(8'h10), 32'hDEADBEEF);
    txn(1'b0, 8'h10, 32'h0, 4'h0, lat, rd, err);
    chk("rd10_lat", 32'(lat), 32'd3);
    chk("rd10_data", rd, 32'hDEADBEEF);

    // Partial byte enables keep fixed latency
    txn(1'b1, 8'h20, 32'h11223344, 4'hF, lat, rd, err);
    base = we_pulses;
    txn(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, lat, rd, err);
    chk("wrbe_lat", 32'(lat), 32'd5);
    chk("wrbe_we_count", 32'(we_pulses - base), 32'd2);
    txn(1'b0, 8'h20, 32'h0, 4'h0, lat, rd, err);
    chk("rdbe_data", rd, 32'h11BB33DD);

    // Range boundary
    base = re_pulses;
    txn(1'b0, 8'hFD, 32'h0, 4'h0, lat, rd, err);
    chk("oob_lat", 32'(lat), 32'd1);
    chk("oob_err", 32'(err), 32'd1);
    chk("oob_rdata", rd, 32'd0);
    chk("oob_no_re", 32'(re_pulses - base), 32'd0);
    txn(1'b1, 8'hFC, 32'h87654321, 4'hF, lat, rd, err);
    chk("wrfc_err", 32'(err), 32'd0);
    txn(1'b0, 8'hFC, 32'h0, 4'h0, lat, rd, err);
    chk("rdfc_err", 32'(err), 32'd0);
    chk("rdfc_data", rd, 32'h87654321);

    // Response backpressure with a competing request held on the input
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    @(posedge clk); #1;
    req_addr = 8'h20;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd3);
    hold_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!rsp_valid || req_ready || rsp_rdata !== 32'hDEADBEEF) hold_ok = 1'b0;
    end
    chk("bp_hold_stable", 32'(hold_ok), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_lat", 32'(lat), 32'd3);
    chk("bp_next_data", rsp_rdata, 32'h11BB33DD);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Unaligned access
    txn(1'b1, 8'h05, 32'h01020304, 4'hF, lat, rd, err);
    txn(1'b0, 8'h05, 32'h0, 4'h0, lat, rd, err);
    chk("un05_data", rd, 32'h01020304);
    txn(1'b0, 8'h04, 32'h0, 4'h0, lat, rd, err);
    chk("un04_data", rd, 32'h02030400);

    // Reset during write beat 2
    txn(1'b1, 8'h40, 32'h55555555, 4'hF, lat, rd, err);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstw_we_before", 32'(mem_we), 32'd1);
    chk("rstw_addr_before", 32'(mem_addr), 32'h42);
    rst = 1'b1;
    #1;
    chk("rstw_we_drop", 32'(mem_we), 32'd0);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstw_mem", mem_word(8'h40), 32'h5555F00D);
    txn(1'b0, 8'h40, 32'h0, 4'h0, lat, rd, err);
    chk("rstw_readback", rd, 32'h5555F00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
